// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and fixed-latency busy window.
// Build option MDU_ITER_DIV_EN selects a 33-cycle restoring divider instead of combinational divide.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write immediately
// RUN   | busy, cnt_q counts N..1; writeback on the cnt_q==1 edge
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [5:0] N_MUL = 6'd5;
`ifdef MDU_ITER_DIV_EN
  localparam logic [5:0] N_DIV = 6'd33;
`else
  localparam logic [5:0] N_DIV = 6'd10;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_signed, is_div;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] q_mag, r_mag, div_q, div_r;
  logic        q_neg, r_neg;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  assign a_ext = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = a_ext * b_ext;

`ifdef MDU_ITER_DIV_EN
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [32:0] shifted;
  logic        ge;
  logic        in_sgn;
  logic [31:0] in_a_mag, in_b_mag;

  assign in_sgn   = ~op[0];
  assign in_a_mag = (in_sgn & rs_data[31]) ? -rs_data : rs_data;
  assign in_b_mag = (in_sgn & rt_data[31]) ? -rt_data : rt_data;
  assign shifted  = {rem_q, quo_q[31]};
  assign ge       = shifted >= {1'b0, dvs_q};
  assign q_mag    = quo_q;
  assign r_mag    = rem_q;
`else
  logic [31:0] a_mag, b_mag;

  // Divide on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag = (is_signed & a_q[31]) ? -a_q : a_q;
  assign b_mag = (is_signed & b_q[31]) ? -b_q : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
`endif

  assign q_neg = is_signed & (a_q[31] ^ b_q[31]);
  assign r_neg = is_signed & a_q[31];
  assign div_q = q_neg ? -q_mag : q_mag;
  assign div_r = r_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_ITER_DIV_EN
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              state_d = RUN;
              cnt_d   = op[1] ? N_DIV : N_MUL;
              op_d    = op[1:0];
              a_d     = rs_data;
              b_d     = rt_data;
`ifdef MDU_ITER_DIV_EN
              rem_d   = 32'd0;
              quo_d   = in_a_mag;
              dvs_d   = in_b_mag;
`endif
            end
            3'd4:    hi_d = rs_data;
            3'd5:    lo_d = rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 6'd1) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
          if (!is_div) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = div_r;
            lo_d = div_q;
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
`ifdef MDU_ITER_DIV_EN
          // 32 shift/subtract steps on counts 33..2; count 1 is sign fix-up and writeback.
          if (is_div) begin
            rem_d = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
            quo_d = {quo_q[30:0], ge};
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_ITER_DIV_EN
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_ITER_DIV_EN
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level HI/LO model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef MDU_ITER_DIV_EN
  localparam int NDIV = 33;
`else
  localparam int NDIV = 10;
`endif
  localparam int NMUL = 5;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: result computed at acceptance with 64-bit arithmetic,
  // released after the busy window elapses.
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          m_rem = 0;
  bit          m_pv = 0;
  bit          cmp_en = 0;

  always @(posedge clk) begin
    longint          sa, sb, sr;
    longint unsigned ua, ub, ur;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_pv = 0; cmp_en = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pv) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      sa = longint'($signed(rs_data)); sb = longint'($signed(rt_data));
      ua = {32'd0, rs_data};           ub = {32'd0, rt_data};
      case (op)
        3'd0: begin sr = sa * sb; p_hi = sr[63:32]; p_lo = sr[31:0]; m_pv = 1; m_rem = NMUL; end
        3'd1: begin ur = ua * ub; p_hi = ur[63:32]; p_lo = ur[31:0]; m_pv = 1; m_rem = NMUL; end
        3'd2: begin
          m_pv = (rt_data != 0); m_rem = NDIV;
          if (m_pv) begin sr = sa / sb; p_lo = sr[31:0]; sr = sa % sb; p_hi = sr[31:0]; end
        end
        3'd3: begin
          m_pv = (rt_data != 0); m_rem = NDIV;
          if (m_pv) begin ur = ua / ub; p_lo = ur[31:0]; ur = ua % ub; p_hi = ur[31:0]; end
        end
        3'd4: m_hi = rs_data;
        3'd5: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_rem > 0});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  // Called at a negedge; leaves the bench at the first negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin n_chk++; n_fail++; $display("FAIL busy_timeout: busy stuck after %0d cycles", n); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 0; rt_data = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    chk("mult_cycles", n, NMUL);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    chk("multu_cycles", n, NMUL);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_cycles", n, NDIV);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    issue(3'd4, 32'h11, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    issue(3'd5, 32'h22, 32'd0);
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    chk("divz_cycles", n, NDIV);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    issue(3'd5, 32'h1234, 32'd0);
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'd0, 32'd5, 32'd5);
    count_busy(n);
    chk("b2b_cycles", n + 2, NDIV);
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);
    issue(3'd1, 32'd6, 32'd7);
    count_busy(n);
    chk("b2b_next_cycles", n, NMUL);
    chk("b2b_next_lo", lo, 32'd42);

    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_wb_lo", lo, 32'd0);

    issue(3'd4, 32'd9, 32'd0);
    reset = 1'b1; start = 1'b1; op = 3'd4; rs_data = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_hi", hi, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 149) == 0);
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom_range(0, 7));
      rs_data = pick();
      rt_data = pick();
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
